// File: rtl/bus_src_sel_pipe_pkg.sv
// Shared definitions for the bus source selector: skid-buffer state encoding
// and a constant-foldable ceiling-log2 used to size the binary select.
package bus_src_sel_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage : bus_src_sel_pipe_pkg

// File: rtl/bus_src_sel_pipe_src_select_comb.sv
// Combinational N-to-1 source selector. Returns zero data and flags
// sel_illegal_o when the select does not name exactly one existing source.
module src_select_comb
    import bus_src_sel_pipe_pkg::*;
#(
    parameter int NUM_SRC    = 64,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = clog2(NUM_SRC),
    parameter bit ONEHOT     = 1'b0
) (
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data_i,
    input  logic [SEL_WIDTH-1:0]          sel_i,
    input  logic [NUM_SRC-1:0]            sel_oh_i,
    output logic [DATA_WIDTH-1:0]         sel_data_o,
    output logic                          sel_illegal_o
);

    if (ONEHOT) begin : g_onehot
        logic [DATA_WIDTH-1:0] or_data;
        logic                  unused_sel;

        assign unused_sel = ^sel_i;

        // NOTE: every variable written in always_comb gets a default first,
        // otherwise a path that skips the assignment infers a latch.
        always_comb begin
            or_data = '0;
            for (int k = 0; k < NUM_SRC; k++) begin
                or_data = or_data | (src_data_i[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel_oh_i[k]}});
            end
        end

        // Zero and multi-hot selects both fail the popcount test, so the
        // OR of several sources never reaches the bus.
        assign sel_illegal_o = ($countones(sel_oh_i) != 1);
        assign sel_data_o    = sel_illegal_o ? '0 : or_data;
    end else begin : g_binary
        logic [DATA_WIDTH-1:0] mux_data;
        logic                  hit;
        logic                  unused_sel_oh;

        assign unused_sel_oh = ^sel_oh_i;

        // A select with no matching source (possible when NUM_SRC is not a
        // power of two) leaves hit low and the data at zero.
        always_comb begin
            mux_data = '0;
            hit      = 1'b0;
            for (int k = 0; k < NUM_SRC; k++) begin
                if (sel_i == SEL_WIDTH'(k)) begin
                    mux_data = src_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                    hit      = 1'b1;
                end
            end
        end

        assign sel_illegal_o = !hit;
        assign sel_data_o    = mux_data;
    end

endmodule : src_select_comb

// File: rtl/bus_src_sel_pipe.sv
// N-source bus selector feeding a 2-entry skid buffer with valid/ready on
// both sides and a sticky illegal-select error flag.
module bus_src_sel_pipe
    import bus_src_sel_pipe_pkg::*;
#(
    parameter int NUM_SRC    = 64,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = clog2(NUM_SRC),
    parameter bit ONEHOT     = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    input  logic [SEL_WIDTH-1:0]          in_sel,
    input  logic [NUM_SRC-1:0]            in_sel_oh,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          err,
    input  logic                          err_clr
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_illegal;
    logic                  accept;
    logic                  pop;

    src_select_comb #(
        .NUM_SRC    (NUM_SRC),
        .DATA_WIDTH (DATA_WIDTH),
        .SEL_WIDTH  (SEL_WIDTH),
        .ONEHOT     (ONEHOT)
    ) u_select (
        .src_data_i    (src_data),
        .sel_i         (in_sel),
        .sel_oh_i      (in_sel_oh),
        .sel_data_o    (sel_data),
        .sel_illegal_o (sel_illegal)
    );

    // Both handshake outputs come from registered state only, so out_ready
    // never reaches in_ready combinationally.
    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = head_q;
    assign err       = err_q;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    head_d  = sel_data;
                end
            end
            ST_ONE: begin
                if (accept && !pop) begin
                    state_d = ST_TWO;
                    skid_d  = sel_data;
                end else if (accept && pop) begin
                    head_d  = sel_data;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    state_d = ST_ONE;
                    head_d  = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // A new illegal capture outranks a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (accept && sel_illegal) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    // NOTE: both data entries are reset as well, so out_data reads zero after
    // reset and no unknown value can leak onto the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            err_q   <= err_d;
        end
    end

endmodule : bus_src_sel_pipe

// File: tb/tb_bus_src_sel_pipe.sv
// Bench for bus_src_sel_pipe: binary 64-source, binary 48-source and one-hot
// 8-source instances, driven from vector tables and hand sequences.
module tb_bus_src_sel_pipe;

    typedef struct packed {
        logic        valid;
        logic [7:0]  sel;
        logic        clr;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    logic clk;
    logic rst_n;

    // Instance A: 64 sources, binary select
    logic [64*32-1:0] a_src;
    logic [5:0]       a_in_sel;
    logic [63:0]      a_in_sel_oh;
    logic             a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_err, a_err_clr;
    logic [31:0]      a_out_data;

    // Instance B: 48 sources, binary select
    logic [48*32-1:0] b_src;
    logic [5:0]       b_in_sel;
    logic [47:0]      b_in_sel_oh;
    logic             b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err, b_err_clr;
    logic [31:0]      b_out_data;

    // Instance C: 8 sources, one-hot select
    logic [8*32-1:0]  c_src;
    logic [2:0]       c_in_sel;
    logic [7:0]       c_in_sel_oh;
    logic             c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_err, c_err_clr;
    logic [31:0]      c_out_data;

    int          checks;
    int          failures;
    logic [31:0] a_q[$];
    int          a_pops;

    vec_t a_vec[4];
    vec_t b_vec[9];
    vec_t c_vec[8];

    bus_src_sel_pipe #(.NUM_SRC(64), .DATA_WIDTH(32), .ONEHOT(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .src_data(a_src), .in_sel(a_in_sel), .in_sel_oh(a_in_sel_oh),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .err(a_err), .err_clr(a_err_clr)
    );

    bus_src_sel_pipe #(.NUM_SRC(48), .DATA_WIDTH(32), .ONEHOT(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .src_data(b_src), .in_sel(b_in_sel), .in_sel_oh(b_in_sel_oh),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .err(b_err), .err_clr(b_err_clr)
    );

    bus_src_sel_pipe #(.NUM_SRC(8), .DATA_WIDTH(32), .ONEHOT(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .src_data(c_src), .in_sel(c_in_sel), .in_sel_oh(c_in_sel_oh),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .out_data(c_out_data), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .err(c_err), .err_clr(c_err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    // One clock of instance A with scoreboard bookkeeping for the coming edge.
    task automatic a_cycle();
        if (a_in_valid && a_in_ready) begin
            a_q.push_back(32'hA000_0000 + {26'd0, a_in_sel});
        end
        if (a_out_valid && a_out_ready) begin
            if (a_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_sb_pop: got unexpected output %h, required no output", a_out_data);
            end else begin
                check("a_sb_data", a_out_data, a_q.pop_front());
                a_pops++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Hold in_valid with the given select until instance A accepts it.
    task automatic a_send(input logic [5:0] sel);
        bit done;
        done       = 1'b0;
        a_in_valid = 1'b1;
        a_in_sel   = sel;
        for (int n = 0; n < 20 && !done; n++) begin
            done = a_in_ready;
            a_cycle();
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL a_send_timeout: sel %0d not accepted, required acceptance within 20 cycles", sel);
        end
    endtask

    task automatic a_drain();
        for (int n = 0; n < 20 && a_out_valid; n++) begin
            a_cycle();
        end
        check("a_drain_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("a_drain_queue_left", a_q.size(), 32'd0);
    endtask

    task automatic apply_a(input vec_t v, input int idx);
        a_in_valid  = v.valid;
        a_in_sel    = v.sel[5:0];
        a_err_clr   = v.clr;
        a_out_ready = 1'b1;
        a_cycle();
        a_in_valid = 1'b0;
        a_err_clr  = 1'b0;
        check($sformatf("a_vec%0d_valid", idx), {31'd0, a_out_valid}, {31'd0, v.exp_valid});
        if (v.exp_valid) check($sformatf("a_vec%0d_data", idx), a_out_data, v.exp_data);
        check($sformatf("a_vec%0d_err", idx), {31'd0, a_err}, {31'd0, v.exp_err});
    endtask

    task automatic apply_b(input vec_t v, input int idx);
        b_in_valid = v.valid;
        b_in_sel   = v.sel[5:0];
        b_err_clr  = v.clr;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        b_err_clr  = 1'b0;
        check($sformatf("b_vec%0d_valid", idx), {31'd0, b_out_valid}, {31'd0, v.exp_valid});
        if (v.exp_valid) check($sformatf("b_vec%0d_data", idx), b_out_data, v.exp_data);
        check($sformatf("b_vec%0d_err", idx), {31'd0, b_err}, {31'd0, v.exp_err});
    endtask

    task automatic apply_c(input vec_t v, input int idx);
        c_in_valid  = v.valid;
        c_in_sel_oh = v.sel;
        c_err_clr   = v.clr;
        @(posedge clk);
        #1;
        c_in_valid = 1'b0;
        c_err_clr  = 1'b0;
        check($sformatf("c_vec%0d_valid", idx), {31'd0, c_out_valid}, {31'd0, v.exp_valid});
        if (v.exp_valid) check($sformatf("c_vec%0d_data", idx), c_out_data, v.exp_data);
        check($sformatf("c_vec%0d_err", idx), {31'd0, c_err}, {31'd0, v.exp_err});
    endtask

    initial begin
        int pops0;
        int stalls;

        checks   = 0;
        failures = 0;
        a_pops   = 0;

        //            valid  sel     clr   exp_v  exp_data        exp_err
        a_vec[0] = '{1'b1, 8'd37, 1'b0, 1'b1, 32'hA000_0025, 1'b0};
        a_vec[1] = '{1'b1, 8'd0,  1'b0, 1'b1, 32'hA000_0000, 1'b0};
        a_vec[2] = '{1'b1, 8'd63, 1'b0, 1'b1, 32'hA000_003F, 1'b0};
        a_vec[3] = '{1'b0, 8'd0,  1'b0, 1'b0, 32'h0,         1'b0};

        b_vec[0] = '{1'b1, 8'd47, 1'b0, 1'b1, 32'hB000_002F, 1'b0};
        b_vec[1] = '{1'b1, 8'd50, 1'b0, 1'b1, 32'h0,         1'b1};
        b_vec[2] = '{1'b0, 8'd0,  1'b0, 1'b0, 32'h0,         1'b1};
        b_vec[3] = '{1'b0, 8'd0,  1'b0, 1'b0, 32'h0,         1'b1};
        b_vec[4] = '{1'b0, 8'd0,  1'b1, 1'b0, 32'h0,         1'b0};
        b_vec[5] = '{1'b1, 8'd48, 1'b1, 1'b1, 32'h0,         1'b1};
        b_vec[6] = '{1'b1, 8'd0,  1'b0, 1'b1, 32'hB000_0000, 1'b1};
        b_vec[7] = '{1'b1, 8'd5,  1'b1, 1'b1, 32'hB000_0005, 1'b0};
        b_vec[8] = '{1'b0, 8'd0,  1'b0, 1'b0, 32'h0,         1'b0};

        c_vec[0] = '{1'b1, 8'b0001_0000, 1'b0, 1'b1, 32'hC000_0004, 1'b0};
        c_vec[1] = '{1'b1, 8'b1000_0000, 1'b0, 1'b1, 32'hC000_0007, 1'b0};
        c_vec[2] = '{1'b1, 8'b0000_0000, 1'b0, 1'b1, 32'h0,         1'b1};
        c_vec[3] = '{1'b0, 8'b0000_0000, 1'b1, 1'b0, 32'h0,         1'b0};
        c_vec[4] = '{1'b1, 8'b0011_0000, 1'b0, 1'b1, 32'h0,         1'b1};
        c_vec[5] = '{1'b0, 8'b0000_0000, 1'b1, 1'b0, 32'h0,         1'b0};
        c_vec[6] = '{1'b1, 8'b0000_0001, 1'b0, 1'b1, 32'hC000_0000, 1'b0};
        c_vec[7] = '{1'b0, 8'b1111_1111, 1'b0, 1'b0, 32'h0,         1'b0};

        for (int k = 0; k < 64; k++) a_src[k*32 +: 32] = 32'hA000_0000 + k;
        for (int k = 0; k < 48; k++) b_src[k*32 +: 32] = 32'hB000_0000 + k;
        for (int k = 0; k < 8; k++)  c_src[k*32 +: 32] = 32'hC000_0000 + k;

        // Unused select inputs carry junk to show the mode ignores them.
        a_in_sel = '0; a_in_sel_oh = '1; a_in_valid = 1'b0; a_out_ready = 1'b1; a_err_clr = 1'b0;
        b_in_sel = '0; b_in_sel_oh = '1; b_in_valid = 1'b0; b_out_ready = 1'b1; b_err_clr = 1'b0;
        c_in_sel = 3'd7; c_in_sel_oh = '0; c_in_valid = 1'b0; c_out_ready = 1'b1; c_err_clr = 1'b0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        check("rst_a_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("rst_a_out_data",  a_out_data, 32'd0);
        check("rst_a_in_ready",  {31'd0, a_in_ready}, 32'd1);
        check("rst_a_err",       {31'd0, a_err}, 32'd0);
        check("rst_b_err",       {31'd0, b_err}, 32'd0);
        check("rst_c_out_valid", {31'd0, c_out_valid}, 32'd0);

        for (int i = 0; i < 4; i++) apply_a(a_vec[i], i);
        for (int i = 0; i < 9; i++) apply_b(b_vec[i], i);
        for (int i = 0; i < 8; i++) apply_c(c_vec[i], i);
        a_drain();

        // Backpressure: fill both entries, stall, then release.
        a_out_ready = 1'b0;
        pops0 = a_pops;
        a_send(6'd1);
        a_send(6'd2);
        a_in_valid = 1'b1;
        a_in_sel   = 6'd3;
        check("bp_in_ready_full", {31'd0, a_in_ready}, 32'd0);
        check("bp_head_data",     a_out_data, 32'hA000_0001);
        a_cycle();
        a_cycle();
        check("bp_head_stable",   a_out_data, 32'hA000_0001);
        check("bp_valid_stable",  {31'd0, a_out_valid}, 32'd1);
        check("bp_still_full",    {31'd0, a_in_ready}, 32'd0);
        a_out_ready = 1'b1;
        a_send(6'd3);
        a_in_valid = 1'b0;
        a_drain();
        check("bp_pop_count", a_pops - pops0, 32'd3);

        // Streaming at full rate.
        pops0  = a_pops;
        stalls = 0;
        a_out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a_in_valid = 1'b1;
            a_in_sel   = 6'(i);
            if (!a_in_ready) stalls++;
            if (i > 0 && !a_out_valid) stalls++;
            a_cycle();
        end
        a_in_valid = 1'b0;
        check("stream_bubbles", stalls, 32'd0);
        check("stream_pops_in_window", a_pops - pops0, 32'd99);
        a_drain();
        check("stream_pop_count", a_pops - pops0, 32'd100);

        // Asynchronous reset while holding two entries.
        a_out_ready = 1'b0;
        a_send(6'd8);
        a_send(6'd9);
        a_in_valid = 1'b0;
        check("ar_full_before", {31'd0, a_in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("ar_in_ready",  {31'd0, a_in_ready}, 32'd1);
        check("ar_out_data",  a_out_data, 32'd0);
        a_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
        pops0 = a_pops;
        a_send(6'd5);
        a_in_valid = 1'b0;
        check("ar_after_data", a_out_data, 32'hA000_0005);
        a_drain();
        check("ar_after_pops", a_pops - pops0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bus_src_sel_pipe
